// File: rtl/lcs_frame_reader.sv
// lcs_frame_reader
//   Requesting end of the LCS req/ack byte handshake. Walks FRAME_LEN addresses
//   starting at ADDR_BASE. For each address it raises req, waits for the
//   responder's ack, captures data_rx and offers the byte on a valid/ready port.
//   If ack does not arrive within TIMEOUT cycles, 8'hFF is emitted instead and
//   err_to is set.
// Ports
//   clk, rst            system clock (posedge), asynchronous active-low reset
//   start               1-cycle pulse that begins a frame (ignored while busy)
//   ack, data_rx        responder acknowledge (asynchronous) and its data byte
//   req, addr_lcs       request and address presented to the responder
//   out_data/out_valid  captured byte to the transmitter, held until out_ready
//   out_ready           transmitter accept
//   busy, done, err_to  frame in progress, end-of-frame pulse, sticky timeout flag
module lcs_frame_reader #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned ADDR_BASE = 0,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ack,
    input  logic [7:0]        data_rx,
    output logic              req,
    output logic [ADDR_W-1:0] addr_lcs,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err_to
);

    localparam int unsigned       TCNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(ADDR_BASE);
    // End compare is done at ADDR_W bits so the frame end matches the wrapped counter.
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(ADDR_BASE + FRAME_LEN - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX   = TCNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RELS,
        S_PUSH,
        S_DONE
    } state_t;

    state_t            state_q,     state_d;
    logic              ack_meta_q,  ack_meta_d;
    logic              ack_s_q,     ack_s_d;
    logic [TCNT_W-1:0] tcnt_q,      tcnt_d;
    logic              req_q,       req_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [7:0]        out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              err_to_q,    err_to_d;

    always_comb begin
        state_d     = state_q;
        ack_meta_d  = ack;
        ack_s_d     = ack_meta_q;
        tcnt_d      = tcnt_q;
        req_d       = req_q;
        addr_d      = addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_to_d    = err_to_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = ADDR_FIRST;
                    busy_d   = 1'b1;
                    err_to_d = 1'b0;
                    tcnt_d   = '0;
                    req_d    = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (tcnt_q != TCNT_MAX) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (ack_s_q) begin
                    out_data_d = data_rx;
                    req_d      = 1'b0;
                    state_d    = S_RELS;
                end else if (tcnt_q == TCNT_MAX) begin
                    out_data_d = 8'hFF;
                    err_to_d   = 1'b1;
                    req_d      = 1'b0;
                    state_d    = S_RELS;
                end
            end
            S_RELS: begin
                // Waiting for ack_s low here is what keeps a stale ack from
                // being taken as the answer to the next req.
                if (!ack_s_q) begin
                    out_valid_d = 1'b1;
                    state_d     = S_PUSH;
                end
            end
            S_PUSH: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (addr_q == ADDR_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        tcnt_d  = '0;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
            tcnt_q      <= '0;
            req_q       <= 1'b0;
            addr_q      <= ADDR_FIRST;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_meta_q  <= ack_meta_d;
            ack_s_q     <= ack_s_d;
            tcnt_q      <= tcnt_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_to_q    <= err_to_d;
        end
    end

    assign req       = req_q;
    assign addr_lcs  = addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_to    = err_to_q;

endmodule

// File: tb/tb_lcs_frame_reader.sv
// Testbench for lcs_frame_reader: randomized responder and transmitter models,
// expected bytes queued per frame and checked by an independent monitor.
module tb_lcs_frame_reader;

    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned ADDR_BASE = 0;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned TIMEOUT   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              ack = 1'b0;
    logic [7:0]        data_rx = 8'h00;
    logic              req;
    logic [ADDR_W-1:0] addr_lcs;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              err_to;

    always #5 clk = ~clk;

    lcs_frame_reader #(
        .ADDR_W   (ADDR_W),
        .ADDR_BASE(ADDR_BASE),
        .FRAME_LEN(FRAME_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ack      (ack),
        .data_rx  (data_rx),
        .req      (req),
        .addr_lcs (addr_lcs),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .err_to   (err_to)
    );

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned done_exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          noack_addr = -1;
    int          stale_hold = 0;
    bit          ready_rand = 1'b0;
    bit          bp_en = 1'b0;
    int          bp_addr = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Reference model: the frame's bytes follow directly from the responder rule
    // (data = addr ^ A5) with a missing responder yielding FF.
    task automatic push_frame_exp();
        bit had_to = 1'b0;
        for (int unsigned a = 0; a < FRAME_LEN; a++) begin
            exp_t e;
            e.addr = (ADDR_BASE + a) % (1 << ADDR_W);
            if (int'(e.addr) == noack_addr) begin
                e.data = 32'hFF;
                had_to = 1'b1;
            end else begin
                e.data = (e.addr & 32'hFF) ^ 32'hA5;
            end
            exp_q.push_back(e);
        end
        done_exp_q.push_back(had_to ? 1 : 0);
    endtask

    // Responder: acks after a random delay, holds ack until req falls plus a hold time.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst && req && !ack) begin
                int unsigned a;
                a = addr_lcs;
                if (int'(a) == noack_addr) begin
                    while (req) begin @(posedge clk); #1; end
                end else begin
                    repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
                    if (req) begin
                        data_rx = 8'(a) ^ 8'hA5;
                        ack = 1'b1;
                        while (req) begin @(posedge clk); #1; end
                        repeat ((stale_hold > 0) ? stale_hold : int'($urandom_range(0, 3))) begin
                            @(posedge clk); #1;
                        end
                        if (rst) chk("addr_held_to_ack_fall", addr_lcs, a);
                        ack = 1'b0;
                        data_rx = 8'($urandom);
                    end
                end
            end
        end
    end

    // Transmitter ready driver.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_en && addr_lcs == ADDR_W'(bp_addr)) out_ready = 1'b0;
            else if (ready_rand) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted byte and every done pulse.
    initial begin
        bit req_prev  = 1'b0;
        bit ack_prev  = 1'b0;
        bit done_prev = 1'b0;
        int req_len   = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                req_prev = 1'b0; ack_prev = 1'b0; done_prev = 1'b0; req_len = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_byte actual=%0h expected=none", out_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("byte_data", 32'(out_data), e.data);
                        chk("byte_addr", 32'(addr_lcs), e.addr);
                    end
                end
                if (done) begin
                    chk("done_one_cycle", 32'(done_prev), 0);
                    if (!done_prev) begin
                        if (done_exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_done actual=1 expected=0");
                        end else begin
                            chk("err_to_at_done", 32'(err_to), done_exp_q.pop_front());
                            chk("bytes_left_at_done", 32'(exp_q.size()), 0);
                            chk("busy_low_at_done", 32'(busy), 0);
                        end
                    end
                end
                if (req && !req_prev) chk("req_rise_with_ack_low", 32'(ack_prev), 0);
                if (req) begin
                    req_len++;
                end else begin
                    if (req_prev && noack_addr >= 0 && int'(addr_lcs) == noack_addr)
                        chk("timeout_req_len_ok", 32'(req_len >= int'(TIMEOUT) && req_len <= int'(TIMEOUT) + 2), 1);
                    req_len = 0;
                end
                req_prev = req; ack_prev = ack; done_prev = done;
            end
        end
    end

    task automatic wait_startable();
        int quiet = 0;
        for (int i = 0; i < 500 && quiet < 4; i++) begin
            @(posedge clk); #1;
            quiet = (!busy && !ack) ? quiet + 1 : 0;
        end
        if (quiet < 4) fail_now("wait_startable");
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic run_frame();
        wait_startable();
        push_frame_exp();
        pulse_start();
        chk("busy_after_start", 32'(busy), 1);
        chk("err_to_cleared_by_start", 32'(err_to), 0);
        chk("addr_base_after_start", 32'(addr_lcs), ADDR_BASE);
    endtask

    task automatic wait_frame_end();
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (exp_q.size() == 0 && done_exp_q.size() == 0 && !busy);
        end
        if (!ok) fail_now("frame_end");
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            ok = done;
        end
        if (!ok) fail_now("wait_done");
    endtask

    initial begin
        repeat (3) @(posedge clk); #1;
        chk("rst_req", 32'(req), 0);
        chk("rst_addr", 32'(addr_lcs), ADDR_BASE);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err_to", 32'(err_to), 0);
        rst = 1'b1;

        // Asynchronous reset while a request is outstanding.
        wait_startable();
        push_frame_exp();
        pulse_start();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin @(posedge clk); #1; seen = req; end
            if (!seen) fail_now("req_rise");
        end
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("async_rst_req", 32'(req), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_addr", 32'(addr_lcs), ADDR_BASE);
        exp_q.delete();
        done_exp_q.delete();
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;

        // Normal frames, ready always high and then random.
        repeat (2) begin run_frame(); wait_frame_end(); end
        ready_rand = 1'b1;
        repeat (3) begin run_frame(); wait_frame_end(); end
        ready_rand = 1'b0;

        // Backpressure on the second byte.
        bp_en = 1'b1;
        run_frame();
        begin
            bit seen = 1'b0;
            logic [7:0] cap;
            int bad_v = 0, bad_d = 0, bad_r = 0, bad_a = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                seen = out_valid && (addr_lcs == ADDR_W'(bp_addr));
            end
            if (!seen) fail_now("bp_valid");
            cap = out_data;
            repeat (20) begin
                @(negedge clk);
                if (!out_valid) bad_v++;
                if (out_data != cap) bad_d++;
                if (req) bad_r++;
                if (addr_lcs != ADDR_W'(bp_addr)) bad_a++;
            end
            chk("bp_valid_held", 32'(bad_v), 0);
            chk("bp_data_held", 32'(bad_d), 0);
            chk("bp_req_low", 32'(bad_r), 0);
            chk("bp_addr_held", 32'(bad_a), 0);
        end
        bp_en = 1'b0;
        wait_frame_end();

        // Missing responder at address 1, then a frame that clears err_to.
        noack_addr = 1;
        run_frame();
        wait_frame_end();
        chk("err_to_sticky_after_frame", 32'(err_to), 1);
        noack_addr = -1;
        run_frame();
        wait_frame_end();

        // Stale ack held long after req falls.
        stale_hold = 30;
        run_frame();
        wait_frame_end();
        stale_hold = 0;

        // start while busy and during the done cycle is dropped.
        run_frame();
        repeat (6) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("done_cycle_start_ignored", 32'(busy), 0);
        end
        wait_frame_end();

        // start one cycle after done begins a fresh frame.
        run_frame();
        wait_done();
        @(negedge clk); #1;
        push_frame_exp();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("restart_after_done_busy", 32'(busy), 1);
        chk("restart_after_done_addr", 32'(addr_lcs), ADDR_BASE);
        wait_frame_end();

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
